// File: rtl/wb_uart_pkg.sv
// Shared constants for the Wishbone UART: register offsets, STAT bit positions
// and the TX hand-off state encoding.
package wb_uart_pkg;

  localparam logic [1:0] ADR_STAT = 2'b00;
  localparam logic [1:0] ADR_DATA = 2'b01;
  localparam logic [1:0] ADR_IER  = 2'b10;

  localparam int STAT_RX_AVAIL     = 0;
  localparam int STAT_RX_ERROR     = 1;
  localparam int STAT_RX_OVERRUN   = 2;
  localparam int STAT_TX_BUSY      = 3;
  localparam int STAT_TX_FULL      = 4;
  localparam int STAT_RX_FULL      = 5;
  localparam int STAT_TX_OVERFLOW  = 6;
  localparam int STAT_RX_LEVEL_LSB = 8;
  localparam int STAT_TX_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; full/empty come from the
// pre-edge level, so a push to a full FIFO is rejected even with a pop.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  push_ok, pop_ok;

  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full    = level_q[DEPTH_LOG2];
  assign empty   = (level_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // NOTE: storage is deliberately not reset; pointers and level alone decide
  // which entries are valid, and a resettable RAM would not map to memory.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/uart.sv
// Fixed-baud 8N1 UART engine. rx_avail holds until rx_ack and falls the cycle
// after; rx_error pulses for one cycle on a bad stop bit.
module uart #(
  parameter int clk_freq = 100000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);
  localparam int DIV = clk_freq / baud;
  localparam int CW  = $clog2(DIV + 1);

  logic [2:0]    rxd_sync_q;
  logic          rx_busy_q, rx_avail_q, rx_error_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_data_q;

  logic          tx_busy_q, txd_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;

  assign rx_data  = rx_data_q;
  assign rx_avail = rx_avail_q;
  assign rx_error = rx_error_q;
  assign uart_txd = txd_q;
  assign tx_busy  = tx_busy_q;

  // Start is a falling edge, so a line still low after a bad stop bit
  // does not re-trigger reception.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_sync_q <= 3'b111;
      rx_busy_q  <= 1'b0;
      rx_avail_q <= 1'b0;
      rx_error_q <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[1:0], uart_rxd};
      rx_error_q <= 1'b0;
      if (rx_ack) rx_avail_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rxd_sync_q[2] && !rxd_sync_q[1]) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= CW'(DIV / 2);
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CW'(1);
      end else begin
        rx_cnt_q <= CW'(DIV - 1);
        if (rx_bit_q == 4'd0) begin
          if (rxd_sync_q[1]) rx_busy_q <= 1'b0;
          else               rx_bit_q  <= 4'd1;
        end else if (rx_bit_q < 4'd9) begin
          rx_shift_q <= {rxd_sync_q[1], rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 4'd1;
        end else begin
          rx_busy_q <= 1'b0;
          if (rxd_sync_q[1]) begin
            rx_data_q  <= rx_shift_q;
            rx_avail_q <= 1'b1;
          end else begin
            rx_error_q <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else if (!tx_busy_q) begin
      if (tx_wr) begin
        tx_busy_q  <= 1'b1;
        txd_q      <= 1'b0;
        tx_shift_q <= {1'b1, tx_data};
        tx_cnt_q   <= CW'(DIV - 1);
        tx_bit_q   <= '0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - CW'(1);
    end else if (tx_bit_q == 4'd9) begin
      tx_busy_q <= 1'b0;
    end else begin
      txd_q      <= tx_shift_q[0];
      tx_shift_q <= {1'b1, tx_shift_q[8:1]};
      tx_bit_q   <= tx_bit_q + 4'd1;
      tx_cnt_q   <= CW'(DIV - 1);
    end
  end
endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone slave around the uart engine: RX/TX FIFOs, sticky error flags,
// interrupt enables and a registered level interrupt.
module wb_uart_fifo
  import wb_uart_pkg::*;
#(
  parameter int clk_freq      = 100000000,
  parameter int baud          = 115200,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq_o
);
  logic        req, access, ack_q;
  logic [1:0]  reg_sel;
  logic        wr_stat, wr_data, wr_ier, rd_data;
  logic [31:0] stat, rdata, dat_q;
  logic [2:0]  ier_q, ier_d;
  logic        rx_error_q, rx_error_d, rx_overrun_q, rx_overrun_d;
  logic        tx_overflow_q, tx_overflow_d, irq_q, irq_d;

  logic [7:0]  rx_data, rx_head, tx_head, tx_data_q, tx_data_d;
  logic        rx_avail, rx_error, rx_ack_q, rx_push;
  logic        tx_busy, tx_wr_q, tx_wr_d, tx_pop;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_DEPTH_LOG2:0] rx_level;
  logic [TX_DEPTH_LOG2:0] tx_level;
  tx_state_e   state_q, state_d;

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  // One side effect per access: it happens on the edge that raises ack.
  assign req      = wb_stb_i & wb_cyc_i;
  assign access   = req & ~ack_q;
  assign wb_ack_o = req & ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;
  assign reg_sel  = wb_adr_i[3:2];
  assign wr_stat  = access & wb_we_i & (reg_sel == ADR_STAT);
  assign wr_data  = access & wb_we_i & (reg_sel == ADR_DATA);
  assign wr_ier   = access & wb_we_i & (reg_sel == ADR_IER);
  assign rd_data  = access & ~wb_we_i & (reg_sel == ADR_DATA);
  assign rx_push  = rx_avail & ~rx_ack_q;

  uart #(.clk_freq(clk_freq), .baud(baud)) u_uart (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack_q),
    .tx_data(tx_data_q), .tx_wr(tx_wr_q), .tx_busy(tx_busy)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_data), .pop(rd_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .din(wb_dat_i[7:0]), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    tx_pop    = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: if (!tx_empty && !tx_busy) begin
        tx_pop    = 1'b1;
        tx_data_d = tx_head;
        tx_wr_d   = 1'b1;
        state_d   = WAIT_RISE;
      end
      WAIT_RISE: if (tx_busy)  state_d = WAIT_FALL;
      WAIT_FALL: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A new error event in the same cycle as a W1C wins over the clear.
  always_comb begin
    stat                                       = '0;
    stat[STAT_RX_AVAIL]                        = ~rx_empty;
    stat[STAT_RX_ERROR]                        = rx_error_q;
    stat[STAT_RX_OVERRUN]                      = rx_overrun_q;
    stat[STAT_TX_BUSY]                         = ~tx_empty | tx_busy | (state_q != IDLE);
    stat[STAT_TX_FULL]                         = tx_full;
    stat[STAT_RX_FULL]                         = rx_full;
    stat[STAT_TX_OVERFLOW]                     = tx_overflow_q;
    stat[STAT_RX_LEVEL_LSB +: 8]               = 8'(rx_level);
    stat[STAT_TX_LEVEL_LSB +: 8]               = 8'(tx_level);

    rx_error_d    = (rx_error_q & ~(wr_stat & wb_dat_i[STAT_RX_ERROR])) | rx_error;
    rx_overrun_d  = (rx_overrun_q & ~(wr_stat & wb_dat_i[STAT_RX_OVERRUN])) | (rx_push & rx_full);
    tx_overflow_d = (tx_overflow_q & ~(wr_stat & wb_dat_i[STAT_TX_OVERFLOW])) | (wr_data & tx_full);
    ier_d         = wr_ier ? wb_dat_i[2:0] : ier_q;

    irq_d = (ier_q[0] & stat[STAT_RX_AVAIL]) | (ier_q[1] & ~stat[STAT_TX_BUSY]) |
            (ier_q[2] & (rx_error_q | rx_overrun_q | tx_overflow_q));

    unique case (reg_sel)
      ADR_STAT: rdata = stat;
      ADR_DATA: rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
      ADR_IER:  rdata = {29'd0, ier_q};
      default:  rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q         <= 1'b0;
      dat_q         <= '0;
      ier_q         <= '0;
      rx_error_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      irq_q         <= 1'b0;
      rx_ack_q      <= 1'b0;
      state_q       <= IDLE;
      tx_data_q     <= '0;
      tx_wr_q       <= 1'b0;
    end else begin
      ack_q         <= access;
      if (access) dat_q <= rdata;
      ier_q         <= ier_d;
      rx_error_q    <= rx_error_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      irq_q         <= irq_d;
      rx_ack_q      <= rx_push;
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_wr_q       <= tx_wr_d;
    end
  end
endmodule
